// File: rtl/moldudp64_pkg.sv
// Shared MoldUDP64 definitions for the header encoder and its receive-side decoder.
package moldudp64_pkg;

  // Bus word indices that carry the 20-byte MoldUDP64 header.
  localparam logic [6:0] WORD_IDX_5 = 7'd5;
  localparam logic [6:0] WORD_IDX_6 = 7'd6;
  localparam logic [6:0] WORD_IDX_7 = 7'd7;

  // Special message-count values.
  localparam logic [15:0] MSG_COUNT_EOS       = 16'hFFFF;
  localparam logic [15:0] MSG_COUNT_HEARTBEAT = 16'h0000;

  // The first MoldUDP64 sequence number of a session is 1.
  localparam logic [63:0] SEQ_INIT_DEFAULT = 64'd1;

  // Header emission state.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    W5   = 2'd1,
    W6   = 2'd2,
    W7   = 2'd3
  } enc_state_t;

  // Header-field bit-slice map (LSB position and width inside each bus word).
  // Word 5: sessionID[31:0] above the UDP prefix tail.
  localparam int W5_SID_LSB  = 32;
  localparam int W5_SID_W    = 32;
  localparam int W5_TAIL_LSB = 0;
  localparam int W5_TAIL_W   = 32;
  // Word 6: seq[15:0] above sessionID[79:32].
  localparam int W6_SEQ_LSB  = 48;
  localparam int W6_SEQ_W    = 16;
  localparam int W6_SID_LSB  = 0;
  localparam int W6_SID_W    = 48;
  // Word 7: messageCount above seq[63:16].
  localparam int W7_CNT_LSB  = 48;
  localparam int W7_CNT_W    = 16;
  localparam int W7_SEQ_LSB  = 0;
  localparam int W7_SEQ_W    = 48;

endpackage

// File: rtl/moldudp64_header_encoder.sv
// MoldUDP64 header encoder: emits the 20-byte header as bus words 5, 6, 7 and
// owns the downstream sequence-number / end-of-session state.
module moldudp64_header_encoder
  import moldudp64_pkg::*;
#(
  parameter logic [63:0] SEQ_INIT   = SEQ_INIT_DEFAULT,
  parameter logic [6:0]  FIRST_WORD = WORD_IDX_5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic        startReady,
  input  logic [79:0] sessionID,
  input  logic [15:0] messageCount,
  input  logic [31:0] prefixTail,
  input  logic        seqLoad,
  input  logic [63:0] nextSeqIn,
  output logic [63:0] dataOut,
  output logic [6:0]  counter,
  output logic        outValid,
  input  logic        outReady,
  output logic [63:0] sequenceNumber,
  output logic        ended
);

  enc_state_t  state_reg;
  logic [63:0] data_reg;
  logic [6:0]  counter_reg;
  logic        valid_reg;
  logic [63:0] seq_reg;
  logic        ended_reg;

  // Shadow copies of the fields still needed after word 5 has been built.
  logic [47:0] sid_hi_reg;
  logic [15:0] cnt_reg;
  logic [63:0] seq_shadow_reg;

  logic        accept;
  logic        handshake;
  logic [63:0] word5;
  logic [63:0] word6;
  logic [63:0] word7;
  logic [63:0] seq_sum;

  // Acceptance is purely a function of registered state plus seqLoad/rst.
  assign startReady = (state_reg == IDLE) && !ended_reg && !seqLoad && !rst;
  assign accept     = start && startReady;
  assign handshake  = valid_reg && outReady;

  // Word packing: word 5 comes straight from the inputs on acceptance,
  // words 6 and 7 from the shadow registers.
  always_comb begin
    word5   = {sessionID[31:0], prefixTail};
    word6   = {seq_shadow_reg[15:0], sid_hi_reg};
    word7   = {cnt_reg, seq_shadow_reg[63:16]};
    seq_sum = seq_reg + {48'd0, cnt_reg};
  end

  // Header FSM with registered outputs and sequence-number bookkeeping.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= IDLE;
      data_reg       <= '0;
      counter_reg    <= '0;
      valid_reg      <= 1'b0;
      seq_reg        <= SEQ_INIT;
      ended_reg      <= 1'b0;
      sid_hi_reg     <= '0;
      cnt_reg        <= '0;
      seq_shadow_reg <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (seqLoad) begin
            // A load in IDLE always wins over start (startReady is low).
            seq_reg   <= nextSeqIn;
            ended_reg <= 1'b0;
          end else if (accept) begin
            sid_hi_reg     <= sessionID[79:32];
            cnt_reg        <= messageCount;
            seq_shadow_reg <= seq_reg;
            data_reg       <= word5;
            counter_reg    <= FIRST_WORD;
            valid_reg      <= 1'b1;
            state_reg      <= W5;
          end
        end
        W5: begin
          if (handshake) begin
            data_reg    <= word6;
            counter_reg <= FIRST_WORD + 7'd1;
            state_reg   <= W6;
          end
        end
        W6: begin
          if (handshake) begin
            data_reg    <= word7;
            counter_reg <= FIRST_WORD + 7'd2;
            state_reg   <= W7;
          end
        end
        W7: begin
          if (handshake) begin
            valid_reg <= 1'b0;
            state_reg <= IDLE;
            // Heartbeat and end-of-session leave the sequence untouched.
            if (cnt_reg == MSG_COUNT_EOS) begin
              ended_reg <= 1'b1;
            end else if (cnt_reg != MSG_COUNT_HEARTBEAT) begin
              seq_reg <= seq_sum;
            end
          end
        end
        default: begin
          state_reg <= IDLE;
          valid_reg <= 1'b0;
        end
      endcase
    end
  end

  assign dataOut        = data_reg;
  assign counter        = counter_reg;
  assign outValid       = valid_reg;
  assign sequenceNumber = seq_reg;
  assign ended          = ended_reg;

endmodule

// File: tb/tb_moldudp64_header_encoder.sv
// Self-checking bench for moldudp64_header_encoder: directed scenarios plus
// randomized headers checked against a behavioural sequence model.
module tb_moldudp64_header_encoder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        startReady;
  logic [79:0] sessionID = '0;
  logic [15:0] messageCount = '0;
  logic [31:0] prefixTail = '0;
  logic        seqLoad = 1'b0;
  logic [63:0] nextSeqIn = '0;
  logic [63:0] dataOut;
  logic [6:0]  counter;
  logic        outValid;
  logic        outReady = 1'b0;
  logic [63:0] sequenceNumber;
  logic        ended;

  int checks = 0;
  int errors = 0;

  // Behavioural model of the session state.
  logic [63:0] m_seq;
  logic        m_ended;

  moldudp64_header_encoder dut (
    .clk(clk), .rst(rst), .start(start), .startReady(startReady),
    .sessionID(sessionID), .messageCount(messageCount), .prefixTail(prefixTail),
    .seqLoad(seqLoad), .nextSeqIn(nextSeqIn), .dataOut(dataOut),
    .counter(counter), .outValid(outValid), .outReady(outReady),
    .sequenceNumber(sequenceNumber), .ended(ended)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [79:0] rand80();
    logic [95:0] r;
    r = {$urandom, $urandom, $urandom};
    return r[79:0];
  endfunction

  // Scramble inputs that must be irrelevant outside the acceptance cycle.
  task automatic scramble();
    sessionID    = rand80();
    messageCount = 16'($urandom);
    prefixTail   = $urandom;
    nextSeqIn    = {$urandom, $urandom};
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; start = 1'b0; seqLoad = 1'b0; outReady = 1'b0;
    #1 chk("ready_in_rst", 64'(startReady), 64'd0);
    @(negedge clk);
    chk("rst_valid", 64'(outValid), 64'd0);
    chk("rst_data", dataOut, 64'd0);
    chk("rst_counter", 64'(counter), 64'd0);
    chk("rst_seq", sequenceNumber, 64'd1);
    chk("rst_ended", 64'(ended), 64'd0);
    rst = 1'b0;
    m_seq = 64'd1;
    m_ended = 1'b0;
    $display("reset done");
  endtask

  task automatic load_seq(input logic [63:0] v);
    @(negedge clk);
    seqLoad = 1'b1; nextSeqIn = v;
    #1 chk("ready_during_load", 64'(startReady), 64'd0);
    @(negedge clk);
    seqLoad = 1'b0;
    m_seq = v;
    m_ended = 1'b0;
    chk("load_seq", sequenceNumber, m_seq);
    chk("load_ended", 64'(ended), 64'd0);
    $display("seqLoad %h", v);
  endtask

  // Send one header; stall = cycles of outReady low before each word is taken.
  // load_w6 raises seqLoad while word 6 is pending (it must be ignored).
  task automatic send_header(input logic [79:0] sid, input logic [15:0] cnt,
                             input logic [31:0] tail, input int stall, input bit load_w6);
    logic [63:0] exp_w [3];
    logic [63:0] seq_used;
    seq_used = m_seq;
    exp_w[0] = {sid[31:0], tail};
    exp_w[1] = {seq_used[15:0], sid[79:32]};
    exp_w[2] = {cnt, seq_used[63:16]};
    @(negedge clk);
    sessionID = sid; messageCount = cnt; prefixTail = tail; start = 1'b1;
    #1 chk("ready_before_start", 64'(startReady), 64'd1);
    @(negedge clk);
    start = 1'b0;
    scramble();
    for (int w = 0; w < 3; w++) begin
      seqLoad = load_w6 && (w == 1);
      for (int s = 0; s < stall; s++) begin
        outReady = 1'b0;
        chk("stall_valid", 64'(outValid), 64'd1);
        chk("stall_data", dataOut, exp_w[w]);
        chk("stall_counter", 64'(counter), 64'(5 + w));
        @(negedge clk);
      end
      outReady = 1'b1;
      chk("word_valid", 64'(outValid), 64'd1);
      chk("word_data", dataOut, exp_w[w]);
      chk("word_counter", 64'(counter), 64'(5 + w));
      @(negedge clk);
    end
    seqLoad = 1'b0;
    outReady = 1'b0;
    if (cnt == 16'hFFFF) m_ended = 1'b1;
    else m_seq = m_seq + 64'(cnt);
    chk("post_valid", 64'(outValid), 64'd0);
    chk("post_seq", sequenceNumber, m_seq);
    chk("post_ended", 64'(ended), 64'(m_ended));
    $display("header cnt=%h seq=%h stall=%0d -> next seq %h ended %0d",
             cnt, seq_used, stall, sequenceNumber, ended);
  endtask

  initial begin
    m_seq = 64'd1;
    m_ended = 1'b0;

    // 1. Basic header.
    do_reset();
    send_header(80'h0102030405060708090A, 16'd3, 32'hDEADBEEF, 0, 1'b0);
    chk("basic_seq4", sequenceNumber, 64'd4);

    // 2. Backpressure.
    do_reset();
    send_header(80'h0102030405060708090A, 16'd3, 32'hDEADBEEF, 3, 1'b0);
    chk("bp_seq4", sequenceNumber, 64'd4);

    // 3. Heartbeat then data.
    do_reset();
    send_header(rand80(), 16'd0, $urandom, 1, 1'b0);
    chk("hb_seq1", sequenceNumber, 64'd1);
    send_header(rand80(), 16'd5, $urandom, 0, 1'b0);
    chk("data_seq6", sequenceNumber, 64'd6);

    // 4. Wrap and end of session.
    load_seq(64'hFFFFFFFFFFFFFFFE);
    send_header(rand80(), 16'd4, $urandom, 0, 1'b0);
    chk("wrap_seq2", sequenceNumber, 64'd2);
    send_header(rand80(), 16'hFFFF, $urandom, 2, 1'b0);
    chk("eos_ended", 64'(ended), 64'd1);
    @(negedge clk);
    start = 1'b1;
    #1 chk("eos_ready", 64'(startReady), 64'd0);
    @(negedge clk);
    start = 1'b0;
    chk("eos_no_header", 64'(outValid), 64'd0);
    load_seq(64'd10);
    chk("reload_ended", 64'(ended), 64'd0);

    // 5. Simultaneous seqLoad+start, then seqLoad during W6.
    @(negedge clk);
    start = 1'b1; seqLoad = 1'b1; nextSeqIn = 64'd77;
    sessionID = rand80(); messageCount = 16'd9;
    @(negedge clk);
    start = 1'b0; seqLoad = 1'b0;
    m_seq = 64'd77;
    chk("simul_no_header", 64'(outValid), 64'd0);
    chk("simul_loaded", sequenceNumber, 64'd77);
    send_header(rand80(), 16'd2, $urandom, 2, 1'b1);
    chk("w6_load_ignored", sequenceNumber, 64'd79);

    // 6. Reset mid-header with word 6 pending.
    load_seq(64'd500);
    @(negedge clk);
    sessionID = rand80(); messageCount = 16'd7; start = 1'b1;
    @(negedge clk);
    start = 1'b0; outReady = 1'b1;
    @(negedge clk);
    outReady = 1'b0;
    chk("mid_w6_counter", 64'(counter), 64'd6);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    m_seq = 64'd1; m_ended = 1'b0;
    chk("midrst_valid", 64'(outValid), 64'd0);
    chk("midrst_seq", sequenceNumber, 64'd1);
    #1 chk("midrst_idle_ready", 64'(startReady), 64'd1);
    send_header(rand80(), 16'd12, $urandom, 1, 1'b0);

    // Randomized headers against the model.
    for (int i = 0; i < 24; i++) begin
      logic [15:0] c;
      int pick;
      pick = int'($urandom_range(0, 9));
      if (pick == 0) c = 16'd0;
      else if (pick == 1) c = 16'hFFFE;
      else c = 16'($urandom_range(1, 300));
      if ((i % 8) == 0) load_seq({$urandom, $urandom});
      send_header(rand80(), c, $urandom, int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/moldudp64_header_encoder.md
Name: moldudp64_header_encoder

Overview:
Transmit-side counterpart of the MoldUDP64 header decoder. It builds the 20-byte MoldUDP64 header and emits it as three 64-bit bus words, tagged with word indices 5, 6 and 7, using exactly the bit packing the receive path unpacks. It owns the downstream sequence-number state: auto-advance, heartbeat and end-of-session handling. It sits after the UDP header generator and before the ITCH message payload packer.

Parameters:
SEQ_INIT, 64'd1, sequence number loaded at reset (first MoldUDP64 sequence is 1)
FIRST_WORD, 7'd5, counter value tagged on the first emitted header word

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
start  in  1  request one header; accepted when start && startReady
startReady  out  1  high = encoder can accept start this cycle
sessionID  in  80  session ID, sampled on start acceptance
messageCount  in  16  message count, sampled on start acceptance
prefixTail  in  32  tail of the preceding UDP header, placed in word 5 [31:0], sampled on acceptance
seqLoad  in  1  load nextSeqIn into the sequence register and clear the ended flag
nextSeqIn  in  64  value for seqLoad
dataOut  out  64  header word
counter  out  7  word index of dataOut (5, 6, 7)
outValid  out  1  dataOut/counter valid
outReady  in  1  downstream accept
sequenceNumber  out  64  sequence number of the next header
ended  out  1  end-of-session header has been sent

Behaviour:
- Single clock domain, clk; rst synchronous, active-high, overrides every other input.
- Reset values:
  - state IDLE; dataOut 0; counter 0; outValid 0.
  - sequenceNumber SEQ_INIT; ended 0.
  - startReady is 0 while rst is high.
- startReady = (state==IDLE) && !ended && !seqLoad && !rst. It is combinational from registered state.
- States and transitions:
  - IDLE -> W5 on start acceptance. sessionID, messageCount, prefixTail and the current sequenceNumber are captured in shadow registers.
  - W5 -> W6, W6 -> W7, W7 -> IDLE. Each transition happens only on an outValid && outReady handshake.
- Latency:
  - Start accepted at cycle T -> word 5 valid at T+1.
  - With outReady held high, words arrive on consecutive cycles.
  - Minimum one idle cycle between headers.
- Word packing (shadow values):
  - Word 5: [63:32] = sessionID[31:0], [31:0] = prefixTail.
  - Word 6: [63:48] = seq[15:0], [47:0] = sessionID[79:32].
  - Word 7: [63:48] = messageCount, [47:0] = seq[63:16].
- Counter is FIRST_WORD, FIRST_WORD+1, FIRST_WORD+2 on words 5, 6, 7.
- Handshake: while outValid && !outReady, dataOut, counter and outValid hold stable. outValid never drops without a handshake, except on rst.
- Sequence update, applied on the word-7 handshake:
  - count 1..0xFFFE: sequenceNumber += count, modulo 2^64 (wraps silently).
  - count 0 (heartbeat): unchanged.
  - count 0xFFFF (end of session): unchanged; ended set to 1. startReady stays 0 until seqLoad.
  - The header always carries the pre-update sequence number.
- seqLoad:
  - Honoured only in IDLE: sequenceNumber <= nextSeqIn, ended <= 0.
  - Ignored in W5/W6/W7.
  - Simultaneous with start: the load wins and start is not accepted.
- Reset mid-header: on the next edge return to IDLE with outValid 0. The partial header is abandoned and the sequence number returns to SEQ_INIT.
- start while not ready is ignored. Input values are irrelevant outside the acceptance cycle.

Decomposition:
- Shared package moldudp64_pkg holds:
  - word-index constants (5, 6, 7);
  - MSG_COUNT_EOS = 16'hFFFF, MSG_COUNT_HEARTBEAT = 16'h0;
  - SEQ_INIT default;
  - the state enum (IDLE, W5, W6, W7);
  - a header-field bit-slice map, also usable by the decoder side.
- No sub-module. The packing mux and the sequence adder live inline.

Test Plan:
1. Basic header. Reset, then start with sessionID=80'h0102030405060708090A, messageCount=3, prefixTail=32'hDEADBEEF, outReady=1. Required:
   - counter 5: 64'h0708090A_DEADBEEF
   - counter 6: 64'h0001_010203040506
   - counter 7: 64'h0003_000000000000
   - sequenceNumber becomes 4.
2. Backpressure. Same stimulus with outReady low for 3 cycles at each word. Required: every word holds stable, no word is lost or duplicated, and the final sequenceNumber is 4.
3. Heartbeat then data. Send messageCount=0: word 6 [63:48]=0x0001 and sequenceNumber stays 1. Then send messageCount=5: it carries seq 1 and sequenceNumber becomes 6.
4. End of session and wrap.
   - seqLoad 64'hFFFFFFFFFFFFFFFE, then count 4: word 7 = 64'h0004_FFFFFFFFFFFF and sequenceNumber = 2 (wrap).
   - Then count 0xFFFF: ended=1, startReady=0, and start is ignored.
   - seqLoad 10: ended=0.
5. Simultaneous events. seqLoad and start in the same IDLE cycle: load applied, no header emitted. seqLoad asserted during W6: ignored.
6. Reset mid-header. Assert rst with word 6 pending and outReady=0. Required next cycle: outValid=0, state IDLE, sequenceNumber=1. A new start then emits a complete header.
